// File: rtl/io_port_unit.sv
`default_nettype none
// ============================================================================
// Module   : io_port_unit
// Purpose  : dmem-bus I/O slave with a millisecond timer and a keyboard FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module io_port_unit #(
    parameter int CLK_PER_MS = 50000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_read_in,
    input  logic        dmem_write_in,
    input  logic [29:0] dmem_addr,
    input  logic [31:0] data_reg,
    input  logic [3:0]  dc_byte_w_en,
    input  logic        mem_stall,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    output logic        io_hit,
    output logic [31:0] io_data_out,
    output logic        kbd_irq
);

    localparam int                 c_pre_w      = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int                 c_ptr_w      = $clog2(FIFO_DEPTH);
    localparam int                 c_cnt_w      = c_ptr_w + 1;
    localparam logic [29:0]        c_timer_addr = 30'h1000;
    localparam logic [29:0]        c_kbd_addr   = 30'h1004;
    localparam logic [c_pre_w-1:0] c_pre_last   = c_pre_w'(CLK_PER_MS - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_full   = c_cnt_w'(FIFO_DEPTH);

    // ---------------------------------------------------------------- decode
    logic w_hit_timer;
    logic w_hit_kbd;
    logic w_acc;
    logic w_timer_wr;
    logic w_kbd_rd;
    logic w_kbd_wr;

    assign w_hit_timer = (dmem_addr == c_timer_addr);
    assign w_hit_kbd   = (dmem_addr == c_kbd_addr);
    assign w_acc       = ~mem_stall;
    assign w_timer_wr  = dmem_write_in & w_hit_timer & w_acc;
    assign w_kbd_rd    = dmem_read_in  & w_hit_kbd   & w_acc;
    assign w_kbd_wr    = dmem_write_in & w_hit_kbd   & w_acc;

    // ----------------------------------------------------------------- timer
    logic [31:0]        r_ms_count_q;
    logic [31:0]        w_ms_count_d;
    logic [c_pre_w-1:0] r_prescaler_q;
    logic [c_pre_w-1:0] w_prescaler_d;
    logic               w_tick;

    assign w_tick = (r_prescaler_q == c_pre_last);

    // A CPU write restarts the current millisecond and swallows any tick.
    always_comb begin
        w_ms_count_d  = r_ms_count_q;
        w_prescaler_d = r_prescaler_q + c_pre_w'(1);
        if (w_timer_wr) begin
            w_prescaler_d = '0;
            for (int i = 0; i < 4; i++) begin
                if (dc_byte_w_en[i]) begin
                    w_ms_count_d[8*i +: 8] = data_reg[8*i +: 8];
                end
            end
        end else if (w_tick) begin
            w_prescaler_d = '0;
            w_ms_count_d  = r_ms_count_q + 32'd1;
        end
    end

    // ------------------------------------------------------------------ fifo
    logic [7:0]         r_fifo_mem_q [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr_q;
    logic [c_ptr_w-1:0] w_rd_ptr_d;
    logic [c_ptr_w-1:0] r_wr_ptr_q;
    logic [c_ptr_w-1:0] w_wr_ptr_d;
    logic [c_cnt_w-1:0] r_count_q;
    logic [c_cnt_w-1:0] w_count_d;
    logic               r_overflow_q;
    logic               w_overflow_d;
    logic               r_kbd_irq_q;
    logic               w_kbd_irq_d;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push_ok;
    logic               w_drop;
    logic               w_mem_we;
    logic [7:0]         w_head;

    assign w_empty   = (r_count_q == '0);
    assign w_full    = (r_count_q == c_cnt_full);
    assign w_pop     = w_kbd_rd & ~w_empty;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign w_push_ok = kbd_valid & (~w_full | w_pop);
    assign w_drop    = kbd_valid & w_full & ~w_pop;
    assign w_mem_we  = w_push_ok & ~w_kbd_wr;

    always_comb begin
        w_rd_ptr_d   = r_rd_ptr_q;
        w_wr_ptr_d   = r_wr_ptr_q;
        w_count_d    = r_count_q;
        w_overflow_d = r_overflow_q;
        if (w_kbd_wr) begin
            w_rd_ptr_d   = '0;
            w_wr_ptr_d   = '0;
            w_count_d    = '0;
            w_overflow_d = 1'b0;
        end else begin
            if (w_pop) begin
                w_rd_ptr_d = r_rd_ptr_q + c_ptr_w'(1);
            end
            if (w_push_ok) begin
                w_wr_ptr_d = r_wr_ptr_q + c_ptr_w'(1);
            end
            w_count_d = r_count_q + c_cnt_w'(w_push_ok) - c_cnt_w'(w_pop);
            if (w_drop) begin
                w_overflow_d = 1'b1;
            end else if (w_kbd_rd) begin
                w_overflow_d = 1'b0;
            end
        end
    end

    assign w_kbd_irq_d = (w_count_d != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ms_count_q  <= '0;
            r_prescaler_q <= '0;
            r_rd_ptr_q    <= '0;
            r_wr_ptr_q    <= '0;
            r_count_q     <= '0;
            r_overflow_q  <= 1'b0;
            r_kbd_irq_q   <= 1'b0;
        end else begin
            r_ms_count_q  <= w_ms_count_d;
            r_prescaler_q <= w_prescaler_d;
            r_rd_ptr_q    <= w_rd_ptr_d;
            r_wr_ptr_q    <= w_wr_ptr_d;
            r_count_q     <= w_count_d;
            r_overflow_q  <= w_overflow_d;
            r_kbd_irq_q   <= w_kbd_irq_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_mem_we && !rst) begin
            r_fifo_mem_q[r_wr_ptr_q] <= kbd_data;
        end
    end

    // --------------------------------------------------------------- outputs
    assign w_head = w_empty ? 8'h00 : r_fifo_mem_q[r_rd_ptr_q];

    always_comb begin
        io_data_out = '0;
        if (dmem_read_in) begin
            if (w_hit_timer) begin
                io_data_out = r_ms_count_q;
            end else if (w_hit_kbd) begin
                io_data_out = {r_overflow_q, 22'b0, ~w_empty, w_head};
            end
        end
    end

    assign io_hit  = w_hit_timer | w_hit_kbd;
    assign kbd_irq = r_kbd_irq_q;

endmodule
`default_nettype wire

// File: tb/tb_io_port_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_port_unit
// Purpose  : Directed vector table plus randomized run against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_port_unit;

    localparam int          CLK_PER_MS = 4;
    localparam int          FIFO_DEPTH = 4;
    localparam logic [29:0] c_t        = 30'h1000;
    localparam logic [29:0] c_k        = 30'h1004;

    logic        clk;
    logic        rst;
    logic        rd;
    logic        wr;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        stall;
    logic        kv;
    logic [7:0]  kd;
    logic        hit;
    logic [31:0] dout;
    logic        irq;

    io_port_unit #(
        .CLK_PER_MS (CLK_PER_MS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .dmem_read_in  (rd),
        .dmem_write_in (wr),
        .dmem_addr     (addr),
        .data_reg      (wdata),
        .dc_byte_w_en  (be),
        .mem_stall     (stall),
        .kbd_valid     (kv),
        .kbd_data      (kd),
        .io_hit        (hit),
        .io_data_out   (dout),
        .kbd_irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rd;
        logic        wr;
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        stall;
        logic        kv;
        logic [7:0]  kd;
        logic        e_hit;
        logic [31:0] e_dout;
        logic        e_irq;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Behavioural model: arithmetic timer and a byte queue for the FIFO.
    logic [31:0] m_ms;
    int          m_pre;
    logic [7:0]  m_q[$];
    logic        m_ovf;
    logic        m_irq;

    function automatic void add(input logic r, input logic rd_i, input logic wr_i,
                                input logic [29:0] a, input logic [31:0] d,
                                input logic [3:0] b, input logic s, input logic k,
                                input logic [7:0] kdat, input logic eh,
                                input logic [31:0] ed, input logic ei);
        vec_t v;
        v.rst = r; v.rd = rd_i; v.wr = wr_i; v.addr = a; v.data = d; v.be = b;
        v.stall = s; v.kv = k; v.kd = kdat; v.e_hit = eh; v.e_dout = ed; v.e_irq = ei;
        vecs.push_back(v);
    endfunction

    function automatic void idle(input logic ei);
        add(0, 0, 0, 30'h0, 32'h0, 4'h0, 0, 0, 8'h00, 0, 32'h0, ei);
    endfunction

    function automatic void rd_t(input logic [31:0] ed);
        add(0, 1, 0, c_t, 32'h0, 4'h0, 0, 0, 8'h00, 1, ed, 0);
    endfunction

    function automatic void wr_t(input logic [31:0] d, input logic [3:0] b, input logic s);
        add(0, 0, 1, c_t, d, b, s, 0, 8'h00, 1, 32'h0, 0);
    endfunction

    function automatic void push(input logic [7:0] kdat, input logic ei);
        add(0, 0, 0, 30'h0, 32'h0, 4'h0, 0, 1, kdat, 0, 32'h0, ei);
    endfunction

    function automatic void rd_k(input logic [31:0] ed, input logic ei, input logic s,
                                 input logic k, input logic [7:0] kdat);
        add(0, 1, 0, c_k, 32'h0, 4'h0, s, k, kdat, 1, ed, ei);
    endfunction

    function automatic logic m_hit(input vec_t v);
        return (v.addr == c_t) || (v.addr == c_k);
    endfunction

    function automatic logic [31:0] m_dout(input vec_t v);
        logic ne;
        ne = (m_q.size() != 0);
        if (!v.rd) return 32'h0;
        if (v.addr == c_t) return m_ms;
        if (v.addr == c_k) return {m_ovf, 22'b0, ne, ne ? m_q[0] : 8'h00};
        return 32'h0;
    endfunction

    function automatic void model_step(input vec_t v);
        logic acc;
        logic rdk;
        if (v.rst) begin
            m_ms = 0; m_pre = 0; m_q.delete(); m_ovf = 0; m_irq = 0;
            return;
        end
        acc = !v.stall;
        if (v.wr && acc && v.addr == c_t) begin
            for (int i = 0; i < 4; i++)
                if (v.be[i]) m_ms[8*i +: 8] = v.data[8*i +: 8];
            m_pre = 0;
        end else if (m_pre == CLK_PER_MS - 1) begin
            m_pre = 0;
            m_ms  = m_ms + 1;
        end else begin
            m_pre = m_pre + 1;
        end
        if (v.wr && acc && v.addr == c_k) begin
            m_q.delete();
            m_ovf = 0;
        end else begin
            rdk = v.rd && acc && (v.addr == c_k);
            if (rdk && m_q.size() != 0) void'(m_q.pop_front());
            if (rdk) m_ovf = 0;
            if (v.kv) begin
                if (m_q.size() < FIFO_DEPTH) m_q.push_back(v.kd);
                else m_ovf = 1;
            end
        end
        m_irq = (m_q.size() != 0);
    endfunction

    task automatic chk(input string nm, input int idx, input logic eh,
                       input logic [31:0] ed, input logic ei);
        n_vec++;
        if (hit !== eh || dout !== ed || irq !== ei) begin
            n_bad++;
            $display("FAIL %s[%0d]: got hit=%b data=%h irq=%b, expected hit=%b data=%h irq=%b",
                     nm, idx, hit, dout, irq, eh, ed, ei);
        end
    endtask

    // mode 0: no check, 1: table expectation, 2: model expectation
    task automatic run_vec(input vec_t v, input string nm, input int idx, input int mode);
        @(negedge clk);
        rst = v.rst; rd = v.rd; wr = v.wr; addr = v.addr; wdata = v.data;
        be = v.be; stall = v.stall; kv = v.kv; kd = v.kd;
        #1;
        if (mode == 1) chk(nm, idx, v.e_hit, v.e_dout, v.e_irq);
        else if (mode == 2) chk(nm, idx, m_hit(v), m_dout(v), m_irq);
        @(posedge clk);
        model_step(v);
    endtask

    initial begin
        vec_t v;
        rst = 1; rd = 0; wr = 0; addr = '0; wdata = '0; be = '0;
        stall = 0; kv = 0; kd = '0;
        m_ms = 0; m_pre = 0; m_ovf = 0; m_irq = 0;

        // timer: count, decode miss, byte writes, wrap, write-beats-tick, stall
        add(1, 1, 0, c_t, 32'h0, 4'h0, 0, 0, 8'h00, 1, 32'h0, 0);
        for (int k = 1; k <= 12; k++) rd_t(32'((k - 1) / 4));
        rd_t(32'd3);
        add(0, 1, 0, 30'h1001, 32'h0, 4'h0, 0, 0, 8'h00, 0, 32'h0, 0);
        wr_t(32'hFFFF_FFFF, 4'b1111, 0);
        rd_t(32'hFFFF_FFFF); idle(0); idle(0); rd_t(32'hFFFF_FFFF); rd_t(32'h0);
        wr_t(32'h1234_5678, 4'b1111, 0);
        wr_t(32'h0000_AB00, 4'b0010, 0);
        rd_t(32'h1234_AB78); idle(0); idle(0);
        wr_t(32'h0000_00AA, 4'b0001, 0);
        rd_t(32'h1234_ABAA);
        wr_t(32'h0, 4'b1111, 1);
        rd_t(32'h1234_ABAA); rd_t(32'h1234_ABAA); rd_t(32'h1234_ABAB);
        // fifo basic push/pop and irq lag
        push(8'h1C, 0); push(8'h32, 1);
        rd_k(32'h11C, 1, 0, 0, 8'h00); rd_k(32'h132, 1, 0, 0, 8'h00); rd_k(32'h0, 0, 0, 0, 8'h00);
        // overflow on a fifth byte
        push(8'hA1, 0); push(8'hA2, 1); push(8'hA3, 1); push(8'hA4, 1); push(8'hA5, 1);
        rd_k(32'h8000_01A1, 1, 0, 0, 8'h00); rd_k(32'h1A2, 1, 0, 0, 8'h00);
        rd_k(32'h1A3, 1, 0, 0, 8'h00); rd_k(32'h1A4, 1, 0, 0, 8'h00); rd_k(32'h0, 0, 0, 0, 8'h00);
        // full fifo with simultaneous push and pop
        push(8'hB1, 0); push(8'hB2, 1); push(8'hB3, 1); push(8'hB4, 1);
        rd_k(32'h1B1, 1, 0, 1, 8'hB5); rd_k(32'h1B2, 1, 0, 0, 8'h00); rd_k(32'h1B3, 1, 0, 0, 8'h00);
        rd_k(32'h1B4, 1, 0, 0, 8'h00); rd_k(32'h1B5, 1, 0, 0, 8'h00); rd_k(32'h0, 0, 0, 0, 8'h00);
        // push into empty fifo while reading
        rd_k(32'h0, 0, 0, 1, 8'hC1); rd_k(32'h1C1, 1, 0, 0, 8'h00); idle(0);
        // stalled reads, flush with discarded push, reset mid-stream
        push(8'hD1, 0); push(8'hD2, 1);
        rd_k(32'h1D1, 1, 1, 0, 8'h00); rd_k(32'h1D1, 1, 1, 0, 8'h00); rd_k(32'h1D1, 1, 1, 0, 8'h00);
        rd_k(32'h1D1, 1, 0, 0, 8'h00); rd_k(32'h1D2, 1, 1, 0, 8'h00);
        add(0, 0, 1, c_k, 32'h0, 4'h0, 0, 1, 8'hE1, 1, 32'h0, 1);
        rd_k(32'h0, 0, 0, 0, 8'h00);
        push(8'hF1, 0);
        add(1, 1, 0, c_k, 32'h0, 4'h0, 0, 1, 8'hF2, 1, 32'h1F1, 1);
        rd_k(32'h0, 0, 0, 0, 8'h00);
        rd_t(32'h0);

        v = vecs[0];
        v.rd = 0;
        run_vec(v, "init", 0, 0);
        run_vec(v, "init", 1, 0);
        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], "vec", i, 1);

        // randomized run against the model
        v = vecs[0];
        run_vec(v, "rreset", 0, 0);
        for (int i = 0; i < 3000; i++) begin
            v.rst = ($urandom_range(0, 299) == 0);
            case ($urandom_range(0, 5))
                0, 1:    v.addr = c_k;
                2, 3:    v.addr = c_t;
                4:       v.addr = 30'h1001;
                default: v.addr = 30'($urandom);
            endcase
            v.rd    = ($urandom_range(0, 99) < 50);
            v.wr    = ($urandom_range(0, 99) < 6);
            v.stall = ($urandom_range(0, 99) < 25);
            v.kv    = ($urandom_range(0, 99) < 35);
            v.kd    = 8'($urandom);
            v.be    = 4'($urandom);
            v.data  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom;
            run_vec(v, "rand", i, 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
